// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a configuration handshake and an IDLE/RUN/DONE run controller.
// Counts overlapping hits; a run ends on stop or when an optional hit limit is reached.
module seq_det_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [4:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_max_hits,
  input  logic               start,
  input  logic               stop,
  input  logic               a,
  input  logic               a_valid,
  output logic               match,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned LEN_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic               cfg_ok_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   max_hits_q;
  logic [MAX_LEN-1:0] window_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic               match_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               cfg_ready_q;

  logic [MAX_LEN-1:0] window_d;
  logic [LEN_W-1:0]   fill_d;
  logic [MAX_LEN-1:0] mask_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               hit_c;
  logic               limit_c;
  logic               cfg_len_ok_c;

  // Window/fill after the current bit, and the hit it would produce.
  always_comb begin
    window_d     = {window_q[MAX_LEN-2:0], a};
    fill_d       = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    mask_c       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    hit_c        = (state_q == S_RUN) && a_valid &&
                   (((window_d ^ pattern_q) & mask_c) == '0) && (fill_d == len_q);
    cnt_inc_c    = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
    limit_c      = hit_c && (max_hits_q != '0) && (cnt_inc_c == max_hits_q);
    cfg_len_ok_c = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_ok_q    <= 1'b0;
      pattern_q   <= '0;
      len_q       <= '0;
      max_hits_q  <= '0;
      window_q    <= '0;
      fill_q      <= '0;
      hit_cnt_q   <= '0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            if (cfg_len_ok_c) begin
              pattern_q  <= cfg_pattern;
              len_q      <= cfg_len;
              max_hits_q <= cfg_max_hits;
              cfg_ok_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (start) begin
            if (cfg_ok_q) begin
              state_q     <= S_RUN;
              busy_q      <= 1'b1;
              cfg_ready_q <= 1'b0;
              hit_cnt_q   <= '0;
              window_q    <= '0;
              fill_q      <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (a_valid) begin
            window_q <= window_d;
            fill_q   <= fill_d;
          end
          if (hit_c) begin
            match_q   <= 1'b1;
            hit_cnt_q <= cnt_inc_c;
          end
          // A hit coinciding with stop is still counted before the run ends.
          if (stop || limit_c) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign match     = match_q;
  assign hit_cnt   = hit_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: configuration, detection, limits, stop and reset behaviour.
module tb_seq_det_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [4:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_max_hits;
  logic               start;
  logic               stop;
  logic               a;
  logic               a_valid;
  logic               match;
  logic [CNT_W-1:0]   hit_cnt;
  logic               busy;
  logic               done;
  logic               err;

  int total = 0;
  int bad   = 0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_max_hits(cfg_max_hits),
    .start       (start),
    .stop        (stop),
    .a           (a),
    .a_valid     (a_valid),
    .match       (match),
    .hit_cnt     (hit_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [4:0] len,
                          input logic [CNT_W-1:0] lim);
    cfg_valid    = 1'b1;
    cfg_pattern  = pat;
    cfg_len      = len;
    cfg_max_hits = lim;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bit_step(input logic bit_a, input logic bit_v, input logic exp_m,
                          input string tag);
    a       = bit_a;
    a_valid = bit_v;
    tick();
    chk(tag, 32'(match), 32'(exp_m));
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_max_hits = '0;
    start = 1'b0; stop = 1'b0; a = 1'b0; a_valid = 1'b0;
    tick(); tick();
    chk("rst_match",   32'(match),     32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt),   32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_err",     32'(err),       32'd0);
    chk("rst_ready",   32'(cfg_ready), 32'd1);
    rst = 1'b0;

    // Start with no configuration ever loaded
    do_start();
    chk("nocfg_err",  32'(err),  32'd1);
    chk("nocfg_busy", 32'(busy), 32'd0);
    tick();
    chk("nocfg_busy2", 32'(busy), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_err", 32'(err), 32'd0);

    // Valid config 101/len3, then two rejected configs that must not replace it
    load_cfg(8'b0000_0101, 5'd3, 8'd0);
    chk("cfg3_err", 32'(err), 32'd0);
    load_cfg(8'hFF, 5'd1, 8'd0);
    chk("len1_err", 32'(err), 32'd1);
    load_cfg(8'hFF, 5'd9, 8'd0);
    chk("len9_err", 32'(err), 32'd1);

    do_start();
    chk("run1_busy",  32'(busy),      32'd1);
    chk("run1_ready", 32'(cfg_ready), 32'd0);
    chk("run1_cnt0",  32'(hit_cnt),   32'd0);
    bit_step(1'b1, 1'b1, 1'b0, "p101_b1");
    bit_step(1'b0, 1'b1, 1'b0, "p101_b2");
    bit_step(1'b1, 1'b1, 1'b1, "p101_b3");
    bit_step(1'b0, 1'b1, 1'b0, "p101_b4");
    bit_step(1'b1, 1'b1, 1'b1, "p101_b5");
    chk("p101_cnt", 32'(hit_cnt), 32'd2);
    bit_step(1'b1, 1'b0, 1'b0, "p101_pulse_end");
    stop = 1'b1; tick(); stop = 1'b0;
    chk("p101_done", 32'(done), 32'd1);
    chk("p101_busy", 32'(busy), 32'd0);
    tick();
    chk("p101_done_end", 32'(done),      32'd0);
    chk("p101_ready",    32'(cfg_ready), 32'd1);
    chk("p101_hold",     32'(hit_cnt),   32'd2);

    // 111 with gaps: zeros offered while a_valid is low must be ignored
    load_cfg(8'b0000_0111, 5'd3, 8'd0);
    do_start();
    bit_step(1'b1, 1'b1, 1'b0, "p111_v1");
    bit_step(1'b0, 1'b0, 1'b0, "p111_g1");
    bit_step(1'b1, 1'b1, 1'b0, "p111_v2");
    bit_step(1'b0, 1'b0, 1'b0, "p111_g2");
    bit_step(1'b1, 1'b1, 1'b1, "p111_v3");
    bit_step(1'b0, 1'b0, 1'b0, "p111_g3");
    chk("p111_cnt", 32'(hit_cnt), 32'd1);
    // Overlapping hit arriving together with stop
    stop = 1'b1;
    bit_step(1'b1, 1'b1, 1'b1, "stop_hit_match");
    stop = 1'b0; a_valid = 1'b0;
    chk("stop_hit_cnt",  32'(hit_cnt), 32'd2);
    chk("stop_hit_done", 32'(done),    32'd1);
    chk("stop_hit_busy", 32'(busy),    32'd0);
    tick();
    chk("stop_done_end",  32'(done),  32'd0);
    chk("stop_match_end", 32'(match), 32'd0);

    // 8-bit pattern with hit limit 1: the single hit ends the run
    load_cfg(8'b0111_0001, 5'd8, 8'd1);
    do_start();
    bit_step(1'b0, 1'b1, 1'b0, "p71_b1");
    bit_step(1'b1, 1'b1, 1'b0, "p71_b2");
    bit_step(1'b1, 1'b1, 1'b0, "p71_b3");
    bit_step(1'b1, 1'b1, 1'b0, "p71_b4");
    bit_step(1'b0, 1'b1, 1'b0, "p71_b5");
    bit_step(1'b0, 1'b1, 1'b0, "p71_b6");
    bit_step(1'b0, 1'b1, 1'b0, "p71_b7");
    bit_step(1'b1, 1'b1, 1'b1, "p71_b8");
    a_valid = 1'b0;
    chk("p71_done", 32'(done),    32'd1);
    chk("p71_busy", 32'(busy),    32'd0);
    chk("p71_cnt",  32'(hit_cnt), 32'd1);
    tick();
    chk("p71_done_end", 32'(done),      32'd0);
    chk("p71_ready",    32'(cfg_ready), 32'd1);

    // 000 pattern checks the fill guard; then reset mid-run with hit_cnt=3
    load_cfg(8'b0000_0000, 5'd3, 8'd0);
    do_start();
    bit_step(1'b0, 1'b1, 1'b0, "p000_b1");
    bit_step(1'b0, 1'b1, 1'b0, "p000_b2");
    bit_step(1'b0, 1'b1, 1'b1, "p000_b3");
    bit_step(1'b0, 1'b1, 1'b1, "p000_b4");
    bit_step(1'b0, 1'b1, 1'b1, "p000_b5");
    chk("p000_cnt", 32'(hit_cnt), 32'd3);
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_match", 32'(match),   32'd0);
    chk("midrst_cnt",   32'(hit_cnt), 32'd0);
    chk("midrst_busy",  32'(busy),    32'd0);
    chk("midrst_done",  32'(done),    32'd0);
    chk("midrst_err",   32'(err),     32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_nodone", 32'(done), 32'd0);
    do_start();
    chk("postrst_err",  32'(err),  32'd1);
    chk("postrst_busy", 32'(busy), 32'd0);
    load_cfg(8'b0000_0101, 5'd3, 8'd0);
    do_start();
    chk("reload_busy", 32'(busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
